// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the RGB-to-luma frame loader.
// FSM states, pipeline depth and default frame/coefficient values.
package rgb2gray_pkg;

   typedef enum logic [1:0] {
      LOAD,
      DRAIN,
      HANDOFF,
      WAIT
   } state_t;

   localparam int PIPE_LAT   = 2;
   localparam int DEF_IMG_W  = 128;
   localparam int DEF_IMG_H  = 128;
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_COEF_R = 77;
   localparam int DEF_COEF_G = 150;
   localparam int DEF_COEF_B = 29;

   function automatic int frame_pix(
      input int w,
      input int h
   );
      return w * h;
   endfunction

endpackage

// File: rtl/luma_mac.sv
// Two-stage weighted-sum pipeline: products, then sum and luma.
// GRAY_ROUND_EN selects round-to-nearest with saturation over truncation.
module luma_mac
   import rgb2gray_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int COEF_R = DEF_COEF_R,
   parameter int COEF_G = DEF_COEF_G,
   parameter int COEF_B = DEF_COEF_B
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [23:0]       in_rgb,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [7:0]        out_data,
   output logic              busy
);

   localparam logic [15:0] CR = 16'(COEF_R);
   localparam logic [15:0] CG = 16'(COEF_G);
   localparam logic [15:0] CB = 16'(COEF_B);

   logic              v1;
   logic [15:0]       pr;
   logic [15:0]       pg;
   logic [15:0]       pb;
   logic [ADDR_W-1:0] a1;
   logic [17:0]       sum;
   logic [7:0]        luma;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         pr <= '0;
         pg <= '0;
         pb <= '0;
         a1 <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            pr <= {8'd0, in_rgb[23:16]} * CR;
            pg <= {8'd0, in_rgb[15:8]} * CG;
            pb <= {8'd0, in_rgb[7:0]} * CB;
            a1 <= in_addr;
         end
      end
   end

   assign sum = {2'b00, pr} + {2'b00, pg} + {2'b00, pb};

`ifdef GRAY_ROUND_EN
   logic [9:0] rnd_q;

   assign rnd_q = 10'((sum + 18'd128) >> 8);
   assign luma  = (|rnd_q[9:8]) ? 8'hFF : rnd_q[7:0];
`else
   assign luma = 8'(sum >> 8);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            out_addr <= a1;
            out_data <= luma;
         end
      end
   end

   assign busy = v1 | out_valid;

endmodule

// File: rtl/rgb2gray_loader.sv
// Frame loader: RGB stream in, luma writes out, median-filter handoff.
// Build option: GRAY_ROUND_EN (rounded, saturated luma in luma_mac).
module rgb2gray_loader
   import rgb2gray_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int COEF_R = DEF_COEF_R,
   parameter int COEF_G = DEF_COEF_G,
   parameter int COEF_B = DEF_COEF_B
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [23:0]       s_rgb,
   input  logic              s_last,
   output logic              gray_wen,
   output logic [ADDR_W-1:0] gray_addr,
   output logic [7:0]        gray_wdata,
   output logic              mfe_ready,
   input  logic              mfe_busy,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int CW = ADDR_W + 1;
   localparam int FRAME = frame_pix(IMG_W, IMG_H);
   localparam logic [CW-1:0] FULL = CW'(FRAME);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          is_last;
   logic          pipe_busy;
   logic          done_nx;

   assign s_ready = !reset && (state == LOAD) && (cnt < FULL);
   assign accept  = s_valid && s_ready;
   assign is_last = (cnt == LAST_IDX);
   assign mfe_ready = (state == HANDOFF);

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      unique case (state)
         LOAD:    if (accept && is_last) state_nx = DRAIN;
         DRAIN:   if (!pipe_busy) state_nx = HANDOFF;
         HANDOFF: if (mfe_busy) state_nx = WAIT;
         WAIT: begin
            if (!mfe_busy) begin
               state_nx = LOAD;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   // s_last only flags a framing error; the counter alone ends the frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LOAD;
         cnt        <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_done <= done_nx;
         if (done_nx)
            cnt <= '0;
         else if (accept)
            cnt <= cnt + 1'b1;
         if (accept && (s_last != is_last))
            frame_err <= 1'b1;
      end
   end

   luma_mac #(
      .ADDR_W (ADDR_W),
      .COEF_R (COEF_R),
      .COEF_G (COEF_G),
      .COEF_B (COEF_B)
   ) u_mac (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (accept),
      .in_rgb    (s_rgb),
      .in_addr   (cnt[ADDR_W-1:0]),
      .out_valid (gray_wen),
      .out_addr  (gray_addr),
      .out_data  (gray_wdata),
      .busy      (pipe_busy)
   );

endmodule

// File: doc/rgb2gray_loader.md
Name: rgb2gray_loader

Overview:
- Upstream stage of the median-filter engine.
- Accepts one raster-ordered 128x128 RGB frame over a valid/ready stream and converts each pixel to 8-bit luma.
- Writes luma into the grayscale image memory, address = row*128 + column.
- Raises the engine's `ready` input and holds off the next frame until the engine finishes (busy falls).

Parameters:
- IMG_W, 128, pixels per row
- IMG_H, 128, rows per frame
- ADDR_W, 14, grayscale memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- COEF_R, 77, red weight (Q0.8)
- COEF_G, 150, green weight (Q0.8)
- COEF_B, 29, blue weight (Q0.8); COEF_R+COEF_G+COEF_B must equal 256

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  RGB pixel valid
- s_ready  out  1  loader can accept a pixel
- s_rgb  in  24  pixel {R[23:16],G[15:8],B[7:0]}, unsigned
- s_last  in  1  marks final pixel of the frame
- gray_wen  out  1  grayscale memory write strobe
- gray_addr  out  ADDR_W  grayscale memory write address
- gray_wdata  out  8  luma value
- mfe_ready  out  1  drives median-filter `ready`
- mfe_busy  in  1  median-filter `busy`
- frame_done  out  1  one-cycle pulse when the engine releases the frame
- frame_err  out  1  sticky; s_last position mismatch

Behaviour:
- Reset values: all outputs 0; state LOAD; pixel counter 0; pipeline valid bits 0; frame_err 0. Reset mid-frame discards the partial frame and restarts at address 0.
- Handshake: a transfer occurs when s_valid && s_ready. s_ready = (state==LOAD) && (cnt < IMG_W*IMG_H). s_ready does not depend on s_valid.
- Pipeline, 2 registered stages:
  - S1 registers the three 16-bit products and the address.
  - S2 computes sum (18 bits), luma = sum[15:8], and drives gray_wen=1, gray_addr, gray_wdata.
  - Latency: gray_wen rises 2 cycles after the accepting edge.
  - Throughput: 1 pixel per cycle. No back-pressure from memory.
- Address: counter value at acceptance, incremented per transfer; range 0..IMG_W*IMG_H-1, never wraps within a frame.
- s_last check:
  - s_last on a pixel other than index IMG_W*IMG_H-1, or missing on that pixel, sets frame_err.
  - The counter alone ends the frame; s_last never truncates it.
- FSM:
  - LOAD: accept pixels. After the last pixel is accepted go to DRAIN.
  - DRAIN: wait 2 cycles until both pipeline stages are empty, then go to HANDOFF.
  - HANDOFF: mfe_ready=1. On mfe_busy sampled 1 go to WAIT and drop mfe_ready the same edge.
  - WAIT: mfe_ready=0. On mfe_busy sampled 0: pulse frame_done for 1 cycle, clear the counter, go to LOAD.
- No gray_wen outside LOAD/DRAIN. Memory contents are stable from HANDOFF until frame_done.
- mfe_busy high on entry to HANDOFF: move to WAIT next edge. The bench must not rely on a busy rising edge.
- frame_err clears only on reset.

Optional Feature:
- GRAY_ROUND_EN
  - Defined: luma = min(255, (sum + 128) >> 8). Round-to-nearest with saturation; same 2-cycle latency.
  - Undefined: luma = sum >> 8 (truncation); no saturation logic.

Decomposition:
- Package rgb2gray_pkg holds:
  - FSM state enum {LOAD, DRAIN, HANDOFF, WAIT}
  - PIPE_LAT=2
  - FRAME_PIX = IMG_W*IMG_H localparam function
  - default coefficient constants
- One sub-module, luma_mac: the 2-stage weighted-sum pipeline (valid in/out, address passthrough). The top holds the FSM, counter and handshakes.

Test Plan:
- Single pixel s_rgb=24'hFF0000 at cnt 0 -> 2 cycles later gray_wen=1, gray_addr=0, gray_wdata=76 (77 with GRAY_ROUND_EN).
- Full frame of 24'hFFFFFF with continuous valid -> 16384 writes at consecutive addresses, all data 255. mfe_ready rises 2 cycles after the last write window; s_ready=0 from acceptance of pixel 16383.
- Random s_valid gaps over a full frame, with reference model luma = (77R+150G+29B)>>8 -> every write matches and addresses are gap-free. frame_err stays 0 with s_last on pixel 16383.
- Handoff: drive mfe_busy 1 three cycles after mfe_ready, hold 100 cycles, then 0 -> mfe_ready falls on busy, frame_done pulses once, s_ready returns 1 next cycle with address restarting at 0.
- s_last asserted on pixel 100 -> frame_err=1 and stays set; frame still completes at 16384 pixels.
- Assert reset after 5000 pixels -> all outputs 0 immediately. The next accepted pixel writes address 0, and no write from the discarded frame appears after reset.
